// File: rtl/uart_imem_loader.sv
// Boot loader: frames a host byte stream into 32-bit words, writes them to imem,
// verifies an XOR checksum and gates the CPU run enable on a good frame.
module uart_imem_loader #(
    parameter int unsigned INSTR_MEM_DEPTH = 128,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000,
    parameter bit          AUTO_RUN        = 1'b0,
    localparam int unsigned AW             = $clog2(INSTR_MEM_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_valid,
    input  logic          i_tx_ready,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_valid,
    output logic          o_imem_we,
    output logic [AW-1:0] o_imem_addr,
    output logic [31:0]   o_imem_wdata,
    output logic          o_cpu_run,
    output logic          o_busy,
    output logic          o_err
);

    localparam int unsigned CW = $clog2(INSTR_MEM_DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SyncByte = 8'hA5;
    localparam logic [7:0] AckGood  = 8'h5A;
    localparam logic [7:0] AckBad   = 8'hEE;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StData,
        StCsum,
        StAck,
        StRun
    } state_e;

    localparam state_e ResetState = AUTO_RUN ? StRun : StIdle;

    state_e          r_state, w_state;
    logic            r_err, w_err;
    logic [7:0]      r_csum, w_csum;
    logic [CW-1:0]   r_widx, w_widx;
    logic [CW-1:0]   r_nwords, w_nwords;
    logic [1:0]      r_bidx, w_bidx;
    logic [23:0]     r_word, w_word;
    logic            r_we, w_we;
    logic [AW-1:0]   r_waddr, w_waddr;
    logic [31:0]     r_wdata, w_wdata;
    logic [7:0]      r_tx_data, w_tx_data;
    logic [TW-1:0]   r_timer, w_timer;

    logic            w_in_frame;
    logic            w_timeout;
    logic            w_count_ok;
    logic [CW-1:0]   w_widx_inc;

    assign w_in_frame = (r_state == StCount) || (r_state == StData) || (r_state == StCsum);
    // A byte arriving on the expiry cycle wins over the abort.
    assign w_timeout  = w_in_frame && !i_rx_valid && (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_count_ok = ({24'd0, i_rx_data} <= 32'(INSTR_MEM_DEPTH));
    assign w_widx_inc = r_widx + CW'(1);

    always_comb begin
        w_state   = r_state;
        w_err     = r_err;
        w_csum    = r_csum;
        w_widx    = r_widx;
        w_nwords  = r_nwords;
        w_bidx    = r_bidx;
        w_word    = r_word;
        w_we      = 1'b0;
        w_waddr   = r_waddr;
        w_wdata   = r_wdata;
        w_tx_data = r_tx_data;
        w_timer   = (i_rx_valid || !w_in_frame) ? '0 : r_timer + TW'(1);

        unique case (r_state)
            StIdle, StRun: begin
                if (i_rx_valid && i_rx_data == SyncByte) begin
                    w_state = StCount;
                    w_err   = 1'b0;
                    w_csum  = 8'h00;
                    w_widx  = '0;
                    w_bidx  = 2'd0;
                end
            end
            StCount: begin
                if (i_rx_valid) begin
                    if (w_count_ok) begin
                        w_state  = StData;
                        w_csum   = i_rx_data;
                        w_nwords = (i_rx_data == 8'h00) ? CW'(INSTR_MEM_DEPTH) : CW'(i_rx_data);
                    end else begin
                        w_state   = StAck;
                        w_tx_data = AckBad;
                        w_err     = 1'b1;
                    end
                end
            end
            StData: begin
                if (i_rx_valid) begin
                    w_csum = r_csum ^ i_rx_data;
                    w_bidx = r_bidx + 2'd1;
                    if (r_bidx == 2'd3) begin
                        w_we    = 1'b1;
                        w_waddr = r_widx[AW-1:0];
                        w_wdata = {i_rx_data, r_word};
                        w_widx  = w_widx_inc;
                        if (w_widx_inc == r_nwords) begin
                            w_state = StCsum;
                        end
                    end else begin
                        w_word[8*r_bidx +: 8] = i_rx_data;
                    end
                end
            end
            StCsum: begin
                if (i_rx_valid) begin
                    w_state = StAck;
                    if (i_rx_data == r_csum) begin
                        w_tx_data = AckGood;
                    end else begin
                        w_tx_data = AckBad;
                        w_err     = 1'b1;
                    end
                end
            end
            StAck: begin
                if (i_tx_ready) begin
                    w_state = (r_tx_data == AckGood) ? StRun : StIdle;
                end
            end
            default: w_state = ResetState;
        endcase

        if (w_timeout) begin
            w_state   = StAck;
            w_tx_data = AckBad;
            w_err     = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ResetState;
            r_err     <= 1'b0;
            r_csum    <= 8'h00;
            r_widx    <= '0;
            r_nwords  <= '0;
            r_bidx    <= 2'd0;
            r_word    <= 24'd0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= 32'd0;
            r_tx_data <= 8'h00;
            r_timer   <= '0;
        end else begin
            r_state   <= w_state;
            r_err     <= w_err;
            r_csum    <= w_csum;
            r_widx    <= w_widx;
            r_nwords  <= w_nwords;
            r_bidx    <= w_bidx;
            r_word    <= w_word;
            r_we      <= w_we;
            r_waddr   <= w_waddr;
            r_wdata   <= w_wdata;
            r_tx_data <= w_tx_data;
            r_timer   <= w_timer;
        end
    end

    assign o_tx_data    = r_tx_data;
    assign o_tx_valid   = (r_state == StAck);
    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_waddr;
    assign o_imem_wdata = r_wdata;
    assign o_cpu_run    = (r_state == StRun);
    assign o_busy       = w_in_frame || (r_state == StAck);
    assign o_err        = r_err;

endmodule
